// File: rtl/i2c_bert_pkg.sv
// Shared types and constants for the I2C BERT sequencer slice.
package i2c_bert_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_TX   = 3'd2,
    ST_RX   = 3'd3,
    ST_DONE = 3'd4
  } st_e;

  typedef enum logic {
    PAT_PRBS7 = 1'b0,
    PAT_INC   = 1'b1
  } pat_e;

  // Configuration word field positions
  localparam int CFG_N_LSB    = 0;
  localparam int CFG_N_MSB    = 7;
  localparam int CFG_PAT_BIT  = 8;
  localparam int CFG_SEED_LSB = 9;
  localparam int CFG_SEED_MSB = 15;

  // PRBS7 (x^7 + x^6 + 1) feedback taps and the substitute for an all-zero seed
  localparam int         PRBS7_TAP_HI    = 6;
  localparam int         PRBS7_TAP_LO    = 5;
  localparam logic [6:0] PRBS7_ZERO_SEED = 7'h7F;

  // Runs the LFSR for eight bits: returns {byte (first bit in MSB), next state}
  function automatic logic [14:0] prbs7_run8(input logic [6:0] state);
    logic [6:0] s;
    logic [7:0] q;
    logic       b;
    s = state;
    q = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b = s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO];
      q = {q[6:0], b};
      s = {s[5:0], b};
    end
    return {q, s};
  endfunction

endpackage

// File: rtl/i2c_bert_seq_ctrl_if.sv
// Datapath handshake bundle between the BERT sequencer and the I2C datapath.
interface i2c_bert_seq_ctrl_if;
  logic       dp_req;
  logic       dp_gnt;
  logic       dp_valid;
  logic [7:0] dp_data;
  logic       dp_ready;
  logic       rx_valid;
  logic [7:0] rx_data;

  modport master (
    output dp_req, dp_valid, dp_data,
    input  dp_gnt, dp_ready, rx_valid, rx_data
  );

  modport slave (
    input  dp_req, dp_valid, dp_data,
    output dp_gnt, dp_ready, rx_valid, rx_data
  );
endinterface

// File: rtl/i2c_bert_patgen.sv
// Test pattern generator: PRBS7 or incrementing byte stream.
// The output byte is a pure function of the held state; advance steps to the next byte.
module i2c_bert_patgen
  import i2c_bert_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  pat_e       pat_sel,
  input  logic [6:0] seed,
  input  logic       advance,
  output logic [7:0] data
);

  pat_e        mode_r;
  logic [7:0]  state_r;
  logic [14:0] prbs_s;

  assign prbs_s = prbs7_run8(state_r[6:0]);

  // Select the current byte for the active pattern
  always_comb begin
    data = 8'h00;
    case (mode_r)
      PAT_INC:   data = state_r;
      PAT_PRBS7: data = prbs_s[14:7];
      default:   data = 8'h00;
    endcase
  end

  // Load the seed on run start and step the generator once per sent byte
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_r  <= PAT_PRBS7;
      state_r <= 8'h00;
    end else if (load) begin
      mode_r <= pat_sel;
      if (pat_sel == PAT_INC) begin
        state_r <= {1'b0, seed};
      end else begin
        state_r <= {1'b0, (seed == 7'h00) ? PRBS7_ZERO_SEED : seed};
      end
    end else if (advance) begin
      if (mode_r == PAT_INC) begin
        state_r <= state_r + 8'd1;
      end else begin
        state_r <= {1'b0, prbs_s[6:0]};
      end
    end
  end

endmodule

// File: rtl/i2c_bert_seq_ctrl.sv
// BERT sequencer: requests the datapath, sends N pattern bytes one at a time,
// compares each returned byte and reports error/byte counts, pass and timeout.
module i2c_bert_seq_ctrl
  import i2c_bert_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4095,
  parameter int CNT_W          = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [31:0]         cfg,
  input  logic                start,
  input  logic                abort,
  i2c_bert_seq_ctrl_if.master dp,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [CNT_W-1:0]    err_count,
  output logic [CNT_W-1:0]    byte_count
);

  localparam int                WAIT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};

  st_e               state_r, state_nx_s;
  logic [7:0]        cfg_n_r;
  logic [WAIT_W-1:0] wait_r;
  logic [7:0]        exp_r;
  logic [7:0]        gen_data_s;
  pat_e              pat_sel_s;
  logic              dp_req_r, dp_valid_r, busy_r, done_r, pass_r, timeout_r;
  logic [7:0]        dp_data_r;
  logic [CNT_W-1:0]  err_r, byte_r, err_nx_s, byte_nx_s, n_total_s;
  logic              pass_nx_s, timeout_nx_s;
  logic              kill_s, launch_s, load_s, adv_s, cmp_s, tmo_s, wait_clr_s;
  logic              last_s, mismatch_s, wait_hit_s;
  logic              cfg_unused_s;

  // Reserved configuration bits carry no meaning here
  assign cfg_unused_s = ^cfg[31:16];

  assign kill_s     = abort || !ena;
  assign launch_s   = start && ena && !abort;
  assign n_total_s  = (cfg_n_r == 8'd0) ? CNT_W'(9'd256) : CNT_W'(cfg_n_r);
  assign last_s     = ((byte_r + CNT_W'(1'b1)) == n_total_s);
  assign mismatch_s = (dp.rx_data != exp_r);
  assign wait_hit_s = (wait_r == WAIT_LIMIT);
  assign pat_sel_s  = pat_e'(cfg[CFG_PAT_BIT]);

  i2c_bert_patgen u_patgen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load_s),
    .pat_sel (pat_sel_s),
    .seed    (cfg[CFG_SEED_MSB:CFG_SEED_LSB]),
    .advance (adv_s),
    .data    (gen_data_s)
  );

  // Next-state and per-cycle control strobes
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    adv_s      = 1'b0;
    cmp_s      = 1'b0;
    tmo_s      = 1'b0;
    wait_clr_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (launch_s) begin
          state_nx_s = ST_REQ;
          load_s     = 1'b1;
          wait_clr_s = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (kill_s) begin
          state_nx_s = ST_IDLE;
        end else if (dp.dp_gnt) begin
          state_nx_s = ST_TX;
        end else if (wait_hit_s) begin
          state_nx_s = ST_DONE;
          tmo_s      = 1'b1;
        end else begin
          state_nx_s = ST_REQ;
        end
      end
      ST_TX: begin
        if (kill_s) begin
          state_nx_s = ST_IDLE;
        end else if (dp_valid_r && dp.dp_ready) begin
          state_nx_s = ST_RX;
          adv_s      = 1'b1;
          wait_clr_s = 1'b1;
        end else begin
          state_nx_s = ST_TX;
        end
      end
      ST_RX: begin
        if (kill_s) begin
          state_nx_s = ST_IDLE;
        end else if (dp.rx_valid) begin
          cmp_s      = 1'b1;
          state_nx_s = last_s ? ST_DONE : ST_TX;
        end else if (wait_hit_s) begin
          state_nx_s = ST_DONE;
          tmo_s      = 1'b1;
        end else begin
          state_nx_s = ST_RX;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Next values of the result counters and flags; pass is settled on DONE entry
  always_comb begin
    err_nx_s     = err_r;
    byte_nx_s    = byte_r;
    timeout_nx_s = timeout_r;
    pass_nx_s    = pass_r;
    if (load_s) begin
      err_nx_s     = CNT_ZERO;
      byte_nx_s    = CNT_ZERO;
      timeout_nx_s = 1'b0;
      pass_nx_s    = 1'b0;
    end else begin
      if (cmp_s) begin
        byte_nx_s = byte_r + CNT_W'(1'b1);
        if (mismatch_s && (err_r != CNT_MAX)) begin
          err_nx_s = err_r + CNT_W'(1'b1);
        end else begin
          err_nx_s = err_r;
        end
      end else begin
        byte_nx_s = byte_r;
      end
      if (tmo_s) begin
        timeout_nx_s = 1'b1;
      end else begin
        timeout_nx_s = timeout_r;
      end
      if (state_nx_s == ST_DONE) begin
        pass_nx_s = (err_nx_s == CNT_ZERO) && !timeout_nx_s;
      end else begin
        pass_nx_s = pass_r;
      end
    end
  end

  // State, configuration copy, wait counter and expected-byte registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cfg_n_r <= 8'h00;
      wait_r  <= {WAIT_W{1'b0}};
      exp_r   <= 8'h00;
    end else begin
      state_r <= state_nx_s;
      if (load_s) begin
        cfg_n_r <= cfg[CFG_N_MSB:CFG_N_LSB];
      end
      if (wait_clr_s) begin
        wait_r <= {WAIT_W{1'b0}};
      end else if (!wait_hit_s) begin
        wait_r <= wait_r + WAIT_W'(1'b1);
      end
      if (adv_s) begin
        exp_r <= dp_data_r;
      end
    end
  end

  // Registered outputs, all derived from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dp_req_r   <= 1'b0;
      dp_valid_r <= 1'b0;
      dp_data_r  <= 8'h00;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      timeout_r  <= 1'b0;
      err_r      <= CNT_ZERO;
      byte_r     <= CNT_ZERO;
    end else begin
      dp_req_r   <= (state_nx_s == ST_REQ) || (state_nx_s == ST_TX) || (state_nx_s == ST_RX);
      dp_valid_r <= (state_nx_s == ST_TX);
      if ((state_nx_s == ST_TX) && (state_r != ST_TX)) begin
        dp_data_r <= gen_data_s;
      end
      busy_r     <= (state_nx_s != ST_IDLE);
      done_r     <= (state_nx_s == ST_DONE);
      pass_r     <= pass_nx_s;
      timeout_r  <= timeout_nx_s;
      err_r      <= err_nx_s;
      byte_r     <= byte_nx_s;
    end
  end

  assign dp.dp_req   = dp_req_r;
  assign dp.dp_valid = dp_valid_r;
  assign dp.dp_data  = dp_data_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign pass        = pass_r;
  assign timeout     = timeout_r;
  assign err_count   = err_r;
  assign byte_count  = byte_r;

endmodule
